// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and types; the immediate generator and decode import it too.
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {instr, pc} packets; flush wins over push, push+pop legal at full/empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_pkt_t             din,
  output fetch_pkt_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_pkt_t      mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage has no reset; validity comes from the reset pointers and count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle-latency imem reads under a credit rule,
// buffers {instr, pc} for decode and restarts on redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fetch_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            flush;
  logic            misaligned;
  logic            credit_ok;
  logic            push;
  logic            pop;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_pkt_t      fifo_head;
  fetch_pkt_t      fifo_din;

  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign imem_addr  = pc;
  assign out_valid  = ~fifo_empty;
  assign out_instr  = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign out_pc     = fifo_empty ? '0 : fifo_head.pc;

  // A redirect cancels both the transfer to decode and the returning response.
  assign pop      = out_valid & out_ready & ~flush;
  assign push     = inflight & ~flush;
  assign fifo_din = '{instr: imem_rdata, pc: req_pc};

  // Issue only if everything buffered or returning, minus what leaves now, still fits.
  assign credit_ok = (int'(fifo_count) + int'(inflight)) < (FIFO_DEPTH + int'(out_valid & out_ready));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    flush     = 1'b0;
    unique case (state)
      ST_IDLE: state_nxt = ST_RUN;
      ST_RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (misaligned) state_nxt = ST_HALT;
        end else begin
          imem_req = credit_ok;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      req_pc    <= '0;
      inflight  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= imem_req;
      if (flush) begin
        if (misaligned) fetch_err <= 1'b1;
        else            pc        <= redirect_pc;
      end else if (imem_req) begin
        pc     <= pc + XLEN'(4);
        req_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The credit rule must keep a response from ever landing on a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_full && push && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic
// against an in-order PC-stream scoreboard.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam logic [63:0] RESET_PC   = 64'h0;
  localparam int          FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        fetch_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_err      (fetch_err)
  );

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory: the word for last cycle's address appears this cycle.
  logic [63:0] mem_addr_q = '0;
  always @(posedge clk) mem_addr_q <= imem_addr;
  assign imem_rdata = word_of(mem_addr_q);

  // Reference model: delivered PCs form a +4 stream restarted by each accepted redirect.
  int          m_cyc = 0;
  int          n_pipe = 0;
  int          n_acc = 0;
  bit          m_halt = 1'b0;
  bit          m_run;
  bit          m_redir;
  logic [63:0] exp_out = '0;
  logic [63:0] exp_req = '0;

  always @(negedge clk) begin
    if (rst) begin
      m_cyc = 0; m_halt = 1'b0; n_pipe = 0;
      exp_out = RESET_PC; exp_req = RESET_PC;
    end else begin
      m_run   = (m_cyc >= 1) && !m_halt;
      m_redir = m_run && redirect_valid;
      vectors++;
      if (fetch_err !== m_halt || (m_halt && (imem_req !== 1'b0 || out_valid !== 1'b0))) begin
        miscompares++;
        $display("FAIL sb.halt err=%0b req=%0b valid=%0b want err=%0b", fetch_err, imem_req, out_valid, m_halt);
      end
      if (imem_req !== 1'b0) begin
        vectors++;
        if (!m_run || m_redir || imem_addr !== exp_req) begin
          miscompares++;
          $display("FAIL sb.req addr=%h run=%0b redir=%0b want addr=%h", imem_addr, m_run, m_redir, exp_req);
        end
        exp_req += 4;
        n_pipe++;
      end
      if (out_valid === 1'b1 && out_ready && !m_redir) begin
        vectors++;
        if (out_pc !== exp_out || out_instr !== word_of(exp_out)) begin
          miscompares++;
          $display("FAIL sb.out pc=%h instr=%h want pc=%h instr=%h", out_pc, out_instr, exp_out, word_of(exp_out));
        end
        exp_out += 4;
        n_pipe--;
        n_acc++;
      end
      if (n_pipe > FIFO_DEPTH || n_pipe < 0) begin
        miscompares++;
        $display("FAIL sb.occupancy got=%0d want<=%0d", n_pipe, FIFO_DEPTH);
        n_pipe = 0;
      end
      if (m_redir) begin
        n_pipe = 0;
        if (redirect_pc[1:0] != 2'b00) m_halt = 1'b1;
        else begin
          exp_out = redirect_pc;
          exp_req = redirect_pc;
        end
      end
      m_cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset.imem_req got=%0b want=0", imem_req); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset.out_valid got=%0b want=0", out_valid); end
    vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL reset.fetch_err got=%0b want=0", fetch_err); end
    vectors++; if (out_instr !== 32'h0000_0013) begin miscompares++; $display("FAIL reset.out_instr got=%h want=00000013", out_instr); end
    vectors++; if (out_pc !== 64'h0) begin miscompares++; $display("FAIL reset.out_pc got=%h want=0", out_pc); end
    vectors++; if (imem_addr !== RESET_PC) begin miscompares++; $display("FAIL reset.imem_addr got=%h want=%h", imem_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 64'(4 * (c - 1))) begin
        miscompares++;
        $display("FAIL stream.req c=%0d req=%0b addr=%h want addr=%h", c, imem_req, imem_addr, 64'(4 * (c - 1)));
      end
      vectors++;
      if (out_valid !== (c >= 3) || (c >= 3 && out_pc !== 64'(4 * (c - 3)))) begin
        miscompares++;
        $display("FAIL stream.out c=%0d valid=%0b pc=%h want valid=%0b pc=%h", c, out_valid, out_pc, c >= 3, 64'(4 * (c - 3)));
      end
    end
  endtask

  task automatic test_stall();
    next_cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 64'd24 || imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL stall.hold k=%0d valid=%0b pc=%h req=%0b want valid=1 pc=18 req=0", k, out_valid, out_pc, imem_req);
      end
      if (k < 4) next_cycle();
    end
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_pc !== 64'd24 || imem_req !== 1'b1 || imem_addr !== 64'd32) begin
      miscompares++;
      $display("FAIL stall.release pc=%h req=%0b addr=%h want pc=18 req=1 addr=20", out_pc, imem_req, imem_addr);
    end
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 64'(24 + 4 * k)) begin
        miscompares++;
        $display("FAIL stall.resume k=%0d pc=%h want pc=%h", k, out_pc, 64'(24 + 4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    next_cycle();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h100;
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL redirect.same_cycle req=%0b valid=%0b want req=0 valid=1", imem_req, out_valid);
    end
    next_cycle();
    redirect_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'(32'h100 + 4 * k)) begin
        miscompares++;
        $display("FAIL redirect.refetch k=%0d valid=%0b req=%0b addr=%h", k, out_valid, imem_req, imem_addr);
      end
      next_cycle();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 64'(32'h100 + 4 * k)) begin
        miscompares++;
        $display("FAIL redirect.deliver k=%0d valid=%0b pc=%h want pc=%h", k, out_valid, out_pc, 64'(32'h100 + 4 * k));
      end
      if (k == 0) next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    bit found = 1'b0;
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h200;
    next_cycle(); redirect_pc = 64'h300;
    next_cycle(); redirect_valid = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) found = 1'b1;
      else next_cycle();
    end
    vectors++;
    if (!found || out_pc !== 64'h300) begin
      miscompares++;
      $display("FAIL back_to_back found=%0b pc=%h want pc=300", found, out_pc);
    end
  endtask

  task automatic test_wrap();
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap.top req=%0b addr=%h want addr=fffffffffffffffc", imem_req, imem_addr);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      miscompares++;
      $display("FAIL wrap.zero req=%0b addr=%h want addr=0", imem_req, imem_addr);
    end
    repeat (4) next_cycle();
  endtask

  task automatic test_misaligned();
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h102;
    next_cycle(); redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (fetch_err !== 1'b1 || out_valid !== 1'b0 || imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL misaligned.halt k=%0d err=%0b valid=%0b req=%0b want 1/0/0", k, fetch_err, out_valid, imem_req);
      end
      next_cycle();
      redirect_valid = (k == 0);
      redirect_pc = 64'h400;
    end
    redirect_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (fetch_err !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL misaligned.reset err=%0b valid=%0b want 0/0", fetch_err, out_valid);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL misaligned.resume req=%0b addr=%h want addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    int acc0 = n_acc;
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = {32'h0, $urandom} & ~64'h3;
      if (i == 200) begin
        rst = 1'b1; redirect_valid = 1'b0;
        next_cycle();
        rst = 1'b0; out_ready = ~out_ready;
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || fetch_err !== 1'b0 ||
            out_instr !== 32'h0000_0013 || out_pc !== 64'h0 || imem_addr !== RESET_PC) begin
          miscompares++;
          $display("FAIL random.mid_reset req=%0b valid=%0b err=%0b instr=%h pc=%h addr=%h",
                   imem_req, out_valid, fetch_err, out_instr, out_pc, imem_addr);
        end
      end
    end
    redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (6) next_cycle();
    vectors++;
    if (n_acc - acc0 < 100) begin
      miscompares++;
      $display("FAIL random.throughput delivered=%0d want>=100", n_acc - acc0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_misaligned();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not terminate");
  end

endmodule
